edge_detector_multi: RTL and testbench

- Parametrised successor of the single-bit Mealy rising-edge detector.
- WIDTH independent channels, each with an input synchroniser and a per-channel 2-state Mealy FSM.
- Runtime-selectable edge mode: rise, fall, both or off.
- Single-cycle `tick` outputs plus sticky `pend` flags with per-bit clear, and an aggregated `any_pend` for interrupt use.
- Sits between asynchronous board inputs (buttons, external strobes) and control logic.

---
 rtl/edge_pkg.sv | 25 ++
 rtl/edge_chan.sv | 119 +++++++++++
 rtl/edge_detector_multi.sv | 60 ++++++
 tb/tb_edge_detector_multi.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared constants for the multi-channel edge detector: edge-select modes,
// filtered-level FSM states and the mode-to-polarity gate.
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_ZERO = 1'b0,
        ST_ONE  = 1'b1
    } state_e;

    // True when the selected mode reports an edge of the given polarity.
    function automatic logic edge_enabled(input logic [1:0] mode, input logic rising);
        if (rising) begin
            return (mode == MODE_RISE) || (mode == MODE_BOTH);
        end
        return (mode == MODE_FALL) || (mode == MODE_BOTH);
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: input synchroniser, filtered-level Mealy FSM,
// optional debounce counter (EDGE_DEBOUNCE_EN) and sticky pending bit.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       tick,
    output logic       pend,
    output logic       pend_next
);

    if (SYNC_STAGES < 0 || SYNC_STAGES > 4 || DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_param
        $error("edge_chan: SYNC_STAGES or DB_CYCLES out of range");
    end

    logic lvl_s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign lvl_s = level;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES-1:0] sync_d;

        always_comb begin
            sync_d = (sync_q << 1) | SYNC_STAGES'(level);
        end

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign lvl_s = sync_q[SYNC_STAGES-1];
    end

    state_e state_q;
    state_e state_d;
    logic   fire_ok;
    logic   tick_raw;
    logic   pend_q;

`ifdef EDGE_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The FSM may only move once the disagreement has lasted DB_CYCLES cycles.
    assign fire_ok = (cnt_q == CW'(DB_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if ((lvl_s != state_q) && !fire_ok) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign fire_ok = 1'b1;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        tick_raw = 1'b0;
        case (state_q)
            ST_ZERO: begin
                if (lvl_s && fire_ok) begin
                    state_d  = ST_ONE;
                    tick_raw = edge_enabled(mode, 1'b1);
                end
            end
            ST_ONE: begin
                if (!lvl_s && fire_ok) begin
                    state_d  = ST_ZERO;
                    tick_raw = edge_enabled(mode, 1'b0);
                end
            end
            default: state_d = ST_ZERO;
        endcase
    end

    // With SYNC_STAGES=0 the level reaches the FSM directly, so gate on reset.
    assign tick      = tick_raw & ~reset;
    assign pend_next = (pend_q & ~clr) | tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ZERO;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_next;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/edge_detector_multi.sv
// WIDTH-channel edge detector with shared mode, sticky pend flags and a
// registered any_pend interrupt; debounce is built when EDGE_DEBOUNCE_EN is defined.
module edge_detector_multi
    import edge_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] tick,
    output logic [WIDTH-1:0] pend,
    output logic             any_pend
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("edge_detector_multi: WIDTH out of range");
    end

    logic [WIDTH-1:0] pend_next;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .level    (level[g]),
            .mode     (mode),
            .clr      (clr[g]),
            .tick     (tick[g]),
            .pend     (pend[g]),
            .pend_next(pend_next[g])
        );
    end

    logic any_pend_q;
    logic any_pend_d;

    // Reduce the next pend vector so any_pend changes on the same edge as pend.
    always_comb begin
        any_pend_d = |pend_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_pend_q <= 1'b0;
        end else begin
            any_pend_q <= any_pend_d;
        end
    end

    assign any_pend = any_pend_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Self-checking bench for edge_detector_multi: directed literal scenarios plus
// randomized traffic compared every cycle against a delay-line/edge model.
module tb_edge_detector_multi;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int DB    = 4;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] level = '0;
    logic [1:0]       mode  = 2'b00;
    logic [WIDTH-1:0] clr   = '0;
    logic [WIDTH-1:0] tick;
    logic [WIDTH-1:0] pend;
    logic             any_pend;

    int checks   = 0;
    int failures = 0;

    edge_detector_multi #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC),
        .DB_CYCLES  (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .level   (level),
        .mode    (mode),
        .clr     (clr),
        .tick    (tick),
        .pend    (pend),
        .any_pend(any_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the filtered level follows the input delayed by SYNC
    // clocks; an edge is the filtered level disagreeing with that delayed input.
    logic [WIDTH-1:0] dly [SYNC];
    logic [WIDTH-1:0] filt_m = '0;
    logic [WIDTH-1:0] pend_m = '0;
    logic             anyp_m = 1'b0;
    int               run_m [WIDTH];

    initial begin
        for (int j = 0; j < SYNC; j++) dly[j] = '0;
        for (int i = 0; i < WIDTH; i++) run_m[i] = 0;
    end

    function automatic logic [WIDTH-1:0] exp_tick();
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] t;
        s = dly[SYNC-1];
        t = '0;
        if (reset) return '0;
        for (int i = 0; i < WIDTH; i++) begin
`ifdef EDGE_DEBOUNCE_EN
            if (s[i] != filt_m[i] && run_m[i] == DB - 1) begin
`else
            if (s[i] != filt_m[i]) begin
`endif
                if (s[i]) t[i] = (mode == 2'b00) || (mode == 2'b10);
                else      t[i] = (mode == 2'b01) || (mode == 2'b10);
            end
        end
        return t;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < SYNC; j++) dly[j] <= '0;
            for (int i = 0; i < WIDTH; i++) run_m[i] <= 0;
            filt_m <= '0;
            pend_m <= '0;
            anyp_m <= 1'b0;
        end else begin
            pend_m <= (pend_m & ~clr) | exp_tick();
            anyp_m <= |((pend_m & ~clr) | exp_tick());
`ifdef EDGE_DEBOUNCE_EN
            for (int i = 0; i < WIDTH; i++) begin
                if (dly[SYNC-1][i] != filt_m[i]) begin
                    if (run_m[i] == DB - 1) begin
                        filt_m[i] <= dly[SYNC-1][i];
                        run_m[i]  <= 0;
                    end else begin
                        run_m[i] <= run_m[i] + 1;
                    end
                end else begin
                    run_m[i] <= 0;
                end
            end
`else
            filt_m <= dly[SYNC-1];
`endif
            for (int j = SYNC - 1; j > 0; j--) dly[j] <= dly[j-1];
            dly[0] <= level;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("model_tick", {24'h0, tick}, {24'h0, exp_tick()});
        check("model_pend", {24'h0, pend}, reset ? 32'h0 : {24'h0, pend_m});
        check("model_any_pend", {31'h0, any_pend}, reset ? 32'h0 : {31'h0, anyp_m});
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) begin
            @(negedge clk);
            check("reset_tick", {24'h0, tick}, 32'h0);
            check("reset_pend", {24'h0, pend}, 32'h0);
            check("reset_any_pend", {31'h0, any_pend}, 32'h0);
        end
        next_cycle();
        reset = 1'b0;
        repeat (3) next_cycle();

`ifdef EDGE_DEBOUNCE_EN
        // 3-cycle glitch: filtered away.
        level = 8'h01;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) level = 8'h00;
            @(negedge clk);
            check("db_glitch_tick", {24'h0, tick}, 32'h0);
            next_cycle();
        end
        // 6-cycle pulse: one rise tick 3 cycles after the synchronised rise.
        level = 8'h01;
        for (int k = 0; k < 10; k++) begin
            if (k == 6) level = 8'h00;
            @(negedge clk);
            check("db_pulse_tick", {24'h0, tick}, (k == 5) ? 32'h01 : 32'h0);
            next_cycle();
        end
`else
        // Rise on channel 0 in mode 00.
        level = 8'h01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rise_tick", {24'h0, tick}, (k == 2) ? 32'h01 : 32'h0);
            check("rise_pend", {24'h0, pend}, (k == 3) ? 32'h01 : 32'h0);
            check("rise_any_pend", {31'h0, any_pend}, (k == 3) ? 32'h1 : 32'h0);
            next_cycle();
        end

        // Set/clear race on channel 3.
        clr = 8'h01;
        next_cycle();
        clr   = 8'h00;
        level = 8'h09;
        next_cycle();
        next_cycle();
        clr = 8'h08;
        @(negedge clk);
        check("race_tick", {24'h0, tick}, 32'h08);
        next_cycle();
        @(negedge clk);
        check("race_pend_kept", {24'h0, pend}, 32'h08);
        check("race_any_kept", {31'h0, any_pend}, 32'h1);
        next_cycle();
        clr = 8'h00;
        @(negedge clk);
        check("race_pend_cleared", {24'h0, pend}, 32'h0);
        check("race_any_cleared", {31'h0, any_pend}, 32'h0);
        next_cycle();

        // Mode 10: both edges of a multi-bit pattern.
        level = 8'h00;
        repeat (4) next_cycle();
        mode  = 2'b10;
        level = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("both_rise_tick", {24'h0, tick}, (k == 2) ? 32'hA5 : 32'h0);
            next_cycle();
        end
        level = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("both_fall_tick", {24'h0, tick}, (k == 2) ? 32'hA5 : 32'h0);
            next_cycle();
        end

        // Mode 11: toggling produces nothing, nor does switching back to rise.
        mode = 2'b11;
        clr  = 8'hFF;
        next_cycle();
        clr = 8'h00;
        for (int k = 0; k < 8; k++) begin
            level = (k < 4 && (k % 2) == 1) ? 8'h00 : 8'hFF;
            @(negedge clk);
            check("off_tick", {24'h0, tick}, 32'h0);
            next_cycle();
        end
        mode = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("off_to_rise_tick", {24'h0, tick}, 32'h0);
            next_cycle();
        end
        check("off_pend", {24'h0, pend}, 32'h0);

        // Reset one cycle after a rise on channel 1, level held high.
        level = 8'h00;
        repeat (4) next_cycle();
        clr = 8'hFF;
        next_cycle();
        clr   = 8'h00;
        level = 8'h02;
        next_cycle();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midrst_tick", {24'h0, tick}, 32'h0);
            check("midrst_pend", {24'h0, pend}, 32'h0);
            check("midrst_any_pend", {31'h0, any_pend}, 32'h0);
            next_cycle();
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_reset_tick", {24'h0, tick}, (k == 2) ? 32'h02 : 32'h0);
            next_cycle();
        end
`endif

        // Randomized traffic, checked by the compare process.
        mode = 2'b00;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            level = level ^ (WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom));
            clr   = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            next_cycle();
        end
        reset = 1'b0;
        clr   = '0;
        repeat (6) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
